// File: rtl/commit_trace_checker.sv
// rtl/commit_trace_checker.sv - commit-trace checker: serialises lane commits into a FIFO and compares against an expected stream
//
// Purpose:
//   Accepts up to N_LANES commit events per cycle (GPR, FPR, HI/LO, MEM).
//   Events are stamped and pushed in lane order into a FIFO.
//   The FIFO head is compared with an expected-trace entry delivered over exp_valid/exp_ready.
//   The block counts passes and skips, and freezes a snapshot of the first mismatch.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ev_valid/kind/tag/data   per-lane commit events (lane 0 oldest)
//   exp_valid/ready          expected-entry handshake
//   exp_kind/tag/data/cycle  expected entry fields
//   exp_skip                 expected entry matches any event
//   cfg_check_cyc            also compare cycle stamps
//   cfg_stop_on_err          halt on first mismatch
//   mismatch                 one-cycle pulse per failing compare
//   err_sticky               first mismatch seen
//   overflow                 sticky: an event was dropped
//   halted                   checker is in HALT
//   pass_cnt, skip_cnt       saturating compare counters
//   err_kind/tag/data/cycle  snapshot of the first mismatching event
//   fifo_level               current FIFO occupancy
module commit_trace_checker #(
  parameter int N_LANES    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 16,
  parameter int CYC_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_LANES-1:0]            ev_valid,
  input  logic [2*N_LANES-1:0]          ev_kind,
  input  logic [TAG_W*N_LANES-1:0]      ev_tag,
  input  logic [64*N_LANES-1:0]         ev_data,
  input  logic                          exp_valid,
  output logic                          exp_ready,
  input  logic [1:0]                    exp_kind,
  input  logic [TAG_W-1:0]              exp_tag,
  input  logic [63:0]                   exp_data,
  input  logic [CYC_W-1:0]              exp_cycle,
  input  logic                          exp_skip,
  input  logic                          cfg_check_cyc,
  input  logic                          cfg_stop_on_err,
  output logic                          mismatch,
  output logic                          err_sticky,
  output logic                          overflow,
  output logic                          halted,
  output logic [31:0]                   pass_cnt,
  output logic [31:0]                   skip_cnt,
  output logic [1:0]                    err_kind,
  output logic [TAG_W-1:0]              err_tag,
  output logic [63:0]                   err_data,
  output logic [CYC_W-1:0]              err_cycle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // One extra bit so "space" can represent FIFO_DEPTH plus a same-cycle pop.
  localparam int SPC_W = LVL_W + 1;

  localparam logic [1:0] K_GPR  = 2'd0;
  localparam logic [1:0] K_HILO = 2'd2;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Event storage; contents need no reset because the pointers define validity.
  logic [1:0]       r_mem_kind [FIFO_DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [FIFO_DEPTH];
  logic [63:0]      r_mem_data [FIFO_DEPTH];
  logic [CYC_W-1:0] r_mem_cyc  [FIFO_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CYC_W-1:0] r_cyc;

  logic             r_overflow;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [31:0]      r_pass;
  logic [31:0]      r_skip;
  logic [1:0]       r_err_kind;
  logic [TAG_W-1:0] r_err_tag;
  logic [63:0]      r_err_data;
  logic [CYC_W-1:0] r_err_cyc;

  logic [N_LANES-1:0] w_keep;
  logic [N_LANES-1:0] w_push_en;
  logic [SPC_W-1:0]   w_push_off [N_LANES];
  logic [63:0]        w_lane_data [N_LANES];
  logic [SPC_W-1:0]   w_space;
  logic [SPC_W-1:0]   w_n_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_exp_ready;
  logic               w_halted;
  logic [CYC_W-1:0]   w_stamp;

  logic [1:0]         w_head_kind;
  logic [TAG_W-1:0]   w_head_tag;
  logic [63:0]        w_head_data;
  logic [CYC_W-1:0]   w_head_cyc;
  logic               w_data_eq;
  logic               w_match;
  logic               w_cmp_pass;
  logic               w_cmp_skip;
  logic               w_cmp_fail;

  // Events pushed this cycle carry the value the counter will hold after the edge.
  assign w_stamp = r_cyc + CYC_W'(1);

  // Lane filter: GPR $0 writes are architecturally invisible and are dropped silently.
  // Only HI/LO carries 64 meaningful bits; the unused upper half of the others is stored as zero.
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_keep[i] = ev_valid[i] &&
                  !((ev_kind[2*i +: 2] == K_GPR) && (ev_tag[TAG_W*i +: TAG_W] == '0));
      w_lane_data[i] = (ev_kind[2*i +: 2] == K_HILO) ? ev_data[64*i +: 64]
                                                     : {32'd0, ev_data[64*i +: 32]};
    end
  end

  // A pop in the same cycle frees a slot for this cycle's pushes.
  assign w_space = SPC_W'(FIFO_DEPTH) - SPC_W'(r_level) + SPC_W'(w_pop);

  // Slot allocation in lane order; once space runs out every later survivor is dropped.
  always_comb begin
    w_push_en = '0;
    w_n_push  = '0;
    w_drop    = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      w_push_off[i] = w_n_push;
      if (w_keep[i]) begin
        if (w_n_push < w_space) begin
          w_push_en[i] = 1'b1;
          w_n_push     = w_n_push + SPC_W'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LANES; i++) begin
      if (w_push_en[i]) begin
        r_mem_kind[r_wr_ptr + PTR_W'(w_push_off[i])] <= ev_kind[2*i +: 2];
        r_mem_tag [r_wr_ptr + PTR_W'(w_push_off[i])] <= ev_tag[TAG_W*i +: TAG_W];
        r_mem_data[r_wr_ptr + PTR_W'(w_push_off[i])] <= w_lane_data[i];
        r_mem_cyc [r_wr_ptr + PTR_W'(w_push_off[i])] <= w_stamp;
      end
    end
  end

  assign w_head_kind = r_mem_kind[r_rd_ptr];
  assign w_head_tag  = r_mem_tag[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_cyc  = r_mem_cyc[r_rd_ptr];

  assign w_pop = exp_valid && w_exp_ready;

  always_comb begin
    w_data_eq = (w_head_kind == K_HILO) ? (w_head_data == exp_data)
                                        : (w_head_data[31:0] == exp_data[31:0]);
    w_match   = (w_head_kind == exp_kind) && (w_head_tag == exp_tag) && w_data_eq &&
                (!cfg_check_cyc || (w_head_cyc == exp_cycle));
    w_cmp_skip = w_pop && exp_skip;
    w_cmp_pass = w_pop && !exp_skip && w_match;
    w_cmp_fail = w_pop && !exp_skip && !w_match;
  end

  // FSM next state and state-derived outputs; exp_ready must not look at exp_valid.
  always_comb begin
    w_state_next = r_state;
    w_exp_ready  = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_RUN: begin
        w_exp_ready = (r_level != '0);
        if (w_cmp_fail && cfg_stop_on_err) begin
          w_state_next = S_HALT;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_cyc        <= '0;
      r_overflow   <= 1'b0;
      r_mismatch   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_pass       <= '0;
      r_skip       <= '0;
      r_err_kind   <= '0;
      r_err_tag    <= '0;
      r_err_data   <= '0;
      r_err_cyc    <= '0;
    end else begin
      r_cyc    <= r_cyc + CYC_W'(1);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_level  <= r_level + LVL_W'(w_n_push) - LVL_W'(w_pop);

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      r_mismatch <= w_cmp_fail;

      // Counters stop at all-ones rather than wrapping so long runs never lie.
      if (w_cmp_pass && (r_pass != '1)) begin
        r_pass <= r_pass + 32'd1;
      end
      if (w_cmp_skip && (r_skip != '1)) begin
        r_skip <= r_skip + 32'd1;
      end

      // Only the first failure is kept; later ones just pulse mismatch.
      if (w_cmp_fail && !r_err_sticky) begin
        r_err_sticky <= 1'b1;
        r_err_kind   <= w_head_kind;
        r_err_tag    <= w_head_tag;
        r_err_data   <= w_head_data;
        r_err_cyc    <= w_head_cyc;
      end
    end
  end

  assign exp_ready  = w_exp_ready;
  assign halted     = w_halted;
  assign mismatch   = r_mismatch;
  assign err_sticky = r_err_sticky;
  assign overflow   = r_overflow;
  assign pass_cnt   = r_pass;
  assign skip_cnt   = r_skip;
  assign err_kind   = r_err_kind;
  assign err_tag    = r_err_tag;
  assign err_data   = r_err_data;
  assign err_cycle  = r_err_cyc;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb/tb_commit_trace_checker.sv - self-checking bench for commit_trace_checker against a queue-based reference model
module tb_commit_trace_checker;

  localparam int NL    = 2;
  localparam int DEPTH = 16;
  localparam int TW    = 16;
  localparam int CW    = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NL-1:0]        ev_valid;
  logic [2*NL-1:0]      ev_kind;
  logic [TW*NL-1:0]     ev_tag;
  logic [64*NL-1:0]     ev_data;
  logic                 exp_valid;
  logic                 exp_ready;
  logic [1:0]           exp_kind;
  logic [TW-1:0]        exp_tag;
  logic [63:0]          exp_data;
  logic [CW-1:0]        exp_cycle;
  logic                 exp_skip;
  logic                 cfg_check_cyc;
  logic                 cfg_stop_on_err;
  logic                 mismatch;
  logic                 err_sticky;
  logic                 overflow;
  logic                 halted;
  logic [31:0]          pass_cnt;
  logic [31:0]          skip_cnt;
  logic [1:0]           err_kind;
  logic [TW-1:0]        err_tag;
  logic [63:0]          err_data;
  logic [CW-1:0]        err_cycle;
  logic [$clog2(DEPTH):0] fifo_level;

  commit_trace_checker #(
    .N_LANES(NL), .FIFO_DEPTH(DEPTH), .TAG_W(TW), .CYC_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_tag(ev_tag), .ev_data(ev_data),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind), .exp_tag(exp_tag),
    .exp_data(exp_data), .exp_cycle(exp_cycle), .exp_skip(exp_skip),
    .cfg_check_cyc(cfg_check_cyc), .cfg_stop_on_err(cfg_stop_on_err),
    .mismatch(mismatch), .err_sticky(err_sticky), .overflow(overflow), .halted(halted),
    .pass_cnt(pass_cnt), .skip_cnt(skip_cnt), .err_kind(err_kind), .err_tag(err_tag),
    .err_data(err_data), .err_cycle(err_cycle), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    k;
    logic [TW-1:0] t;
    logic [63:0]   d;
    logic [CW-1:0] c;
  } ev_t;

  // Reference model: the FIFO is a plain queue, everything else is scalar bookkeeping.
  ev_t           mq[$];
  logic [CW-1:0] m_cyc;
  logic [31:0]   m_pass, m_skip;
  logic          m_mism, m_err, m_ovf, m_halt;
  logic [1:0]    m_ek;
  logic [TW-1:0] m_et;
  logic [63:0]   m_ed;
  logic [CW-1:0] m_ec;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cyc = '0; m_pass = '0; m_skip = '0;
    m_mism = 0; m_err = 0; m_ovf = 0; m_halt = 0;
    m_ek = '0; m_et = '0; m_ed = '0; m_ec = '0;
  endtask

  task automatic clear_inputs();
    ev_valid = '0; ev_kind = '0; ev_tag = '0; ev_data = '0;
    exp_valid = 0; exp_kind = '0; exp_tag = '0; exp_data = '0; exp_cycle = '0; exp_skip = 0;
  endtask

  task automatic set_lane(input int i, input logic [1:0] k, input logic [TW-1:0] t, input logic [63:0] d);
    ev_valid[i]        = 1'b1;
    ev_kind[2*i +: 2]  = k;
    ev_tag[TW*i +: TW] = t;
    ev_data[64*i +: 64] = d;
  endtask

  task automatic set_exp(input logic v, input logic [1:0] k, input logic [TW-1:0] t,
                         input logic [63:0] d, input logic [CW-1:0] c, input logic s);
    exp_valid = v; exp_kind = k; exp_tag = t; exp_data = d; exp_cycle = c; exp_skip = s;
  endtask

  // mode 0: exact copy of the model head, 1: skip entry, 2: one field corrupted
  task automatic exp_from_head(input int mode);
    ev_t e;
    e = mq[0];
    if (mode == 2) begin
      case ($urandom % 4)
        0: e.k = e.k ^ 2'($urandom_range(1, 3));
        1: e.t = e.t ^ (TW'(1) << ($urandom % TW));
        2: e.d = e.d ^ (64'd1 << ($urandom % 64));
        default: e.c = e.c ^ (CW'(1) << ($urandom % 8));
      endcase
    end
    set_exp(1'b1, e.k, e.t, e.d, e.c, mode == 1);
  endtask

  task automatic check_outputs(input string p);
    check({p, "_mismatch"}, 64'(mismatch), 64'(m_mism));
    check({p, "_err_sticky"}, 64'(err_sticky), 64'(m_err));
    check({p, "_overflow"}, 64'(overflow), 64'(m_ovf));
    check({p, "_halted"}, 64'(halted), 64'(m_halt));
    check({p, "_pass_cnt"}, 64'(pass_cnt), 64'(m_pass));
    check({p, "_skip_cnt"}, 64'(skip_cnt), 64'(m_skip));
    check({p, "_err_kind"}, 64'(err_kind), 64'(m_ek));
    check({p, "_err_tag"}, 64'(err_tag), 64'(m_et));
    check({p, "_err_data"}, err_data, m_ed);
    check({p, "_err_cycle"}, 64'(err_cycle), 64'(m_ec));
    check({p, "_fifo_level"}, 64'(fifo_level), 64'(mq.size()));
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    logic ready_m, pop, ok;
    ev_t  h, e;
    #1;
    ready_m = !m_halt && (mq.size() != 0);
    check("exp_ready", 64'(exp_ready), 64'(ready_m));
    pop = exp_valid && ready_m;
    m_mism = 0;
    if (pop) begin
      h = mq.pop_front();
      if (exp_skip) begin
        if (m_skip != 32'hFFFF_FFFF) m_skip++;
      end else begin
        ok = (h.k == exp_kind) && (h.t == exp_tag) &&
             ((h.k == 2'd2) ? (h.d == exp_data) : (h.d[31:0] == exp_data[31:0])) &&
             (!cfg_check_cyc || (h.c == exp_cycle));
        if (ok) begin
          if (m_pass != 32'hFFFF_FFFF) m_pass++;
        end else begin
          m_mism = 1;
          if (!m_err) begin
            m_err = 1; m_ek = h.k; m_et = h.t; m_ed = h.d; m_ec = h.c;
          end
          if (cfg_stop_on_err) m_halt = 1;
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      e.k = ev_kind[2*i +: 2];
      e.t = ev_tag[TW*i +: TW];
      e.d = (e.k == 2'd2) ? ev_data[64*i +: 64] : {32'd0, ev_data[64*i +: 32]};
      e.c = m_cyc + 1;
      if (ev_valid[i] && !(e.k == 2'd0 && e.t == '0)) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check("rst_ready", 64'(exp_ready), 64'd0);
    check_outputs("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cfg_check_cyc = 0;
    cfg_stop_on_err = 0;
    do_reset();

    // In-order pair
    set_lane(0, 2'd0, 16'd3, 64'h0000_0000_0000_1234);
    set_lane(1, 2'd3, 16'h0010, 64'h0000_0000_dead_beef);
    step();
    clear_inputs();
    set_exp(1, 2'd0, 16'd3, 64'h1234, '0, 0);
    step();
    set_exp(1, 2'd3, 16'h0010, 64'hdead_beef, '0, 0);
    step();
    clear_inputs();
    step();
    check("t1_pass_cnt", 64'(pass_cnt), 64'd2);
    check("t1_err_sticky", 64'(err_sticky), 64'd0);

    // Lane-order swap with stop-on-error, then grow the halted FIFO to 5
    do_reset();
    cfg_stop_on_err = 1;
    set_lane(0, 2'd0, 16'd3, 64'h1234);
    set_lane(1, 2'd3, 16'h0010, 64'hdead_beef);
    step();
    clear_inputs();
    set_exp(1, 2'd3, 16'h0010, 64'hdead_beef, '0, 0);
    step();
    check("t2_mismatch", 64'(mismatch), 64'd1);
    check("t2_err_kind", 64'(err_kind), 64'd0);
    check("t2_err_tag", 64'(err_tag), 64'd3);
    check("t2_err_data", err_data, 64'h1234);
    check("t2_halted", 64'(halted), 64'd1);
    for (int c = 0; c < 2; c++) begin
      set_lane(0, 2'd1, TW'(c + 5), 64'(c));
      set_lane(1, 2'd0, TW'(c + 7), 64'(c));
      step();
      check("t2_ready_halted", 64'(exp_ready), 64'd0);
    end
    clear_inputs();
    check("t6_level_before", 64'(fifo_level), 64'd5);
    // Asynchronous reset lands mid-phase, away from any rising edge
    #2;
    rst = 1'b1;
    #1;
    check("t6_halted", 64'(halted), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_err_sticky", 64'(err_sticky), 64'd0);
    check("t6_err_tag", 64'(err_tag), 64'd0);
    check("t6_mismatch", 64'(mismatch), 64'd0);
    @(negedge clk);
    cfg_stop_on_err = 0;
    do_reset();
    set_lane(0, 2'd2, 16'd0, 64'h0000_0001_0000_0002);
    step();
    clear_inputs();
    set_exp(1, 2'd2, 16'd0, 64'h0000_0001_0000_0002, '0, 0);
    step();
    check("t6_run_pass", 64'(pass_cnt), 64'd1);

    // Skip and $0 filter
    do_reset();
    set_lane(0, 2'd0, 16'd0, 64'h5);
    set_lane(1, 2'd2, 16'd0, 64'h0000_0001_0000_0002);
    step();
    clear_inputs();
    check("t3_level_one", 64'(fifo_level), 64'd1);
    set_exp(1, 2'd1, 16'h00ff, 64'h0, '0, 1);
    step();
    check("t3_skip_cnt", 64'(skip_cnt), 64'd1);
    check("t3_level", 64'(fifo_level), 64'd0);

    // Cycle-stamp check: exact stamp passes, off-by-one fails
    for (int v = 10; v <= 11; v++) begin
      cfg_check_cyc = 0;
      do_reset();
      cfg_check_cyc = 1;
      while (m_cyc != 9) step();
      set_lane(0, 2'd0, 16'd1, 64'h77);
      step();
      clear_inputs();
      set_exp(1, 2'd0, 16'd1, 64'h77, CW'(v), 0);
      step();
      clear_inputs();
      if (v == 10) begin
        check("t4_pass", 64'(pass_cnt), 64'd1);
      end else begin
        check("t4_mismatch", 64'(mismatch), 64'd1);
        check("t4_err_cycle", 64'(err_cycle), 64'd10);
      end
    end
    cfg_check_cyc = 0;

    // Overflow on the ninth double-push cycle, then drain with matching entries
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      set_lane(0, 2'd0, TW'(2 * c + 1), {$urandom, $urandom});
      set_lane(1, 2'd1, TW'(2 * c + 2), {$urandom, $urandom});
      step();
      if (c == 8) check("t5_no_ovf_c8", 64'(overflow), 64'd0);
    end
    clear_inputs();
    check("t5_level", 64'(fifo_level), 64'd16);
    check("t5_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      exp_from_head(0);
      step();
    end
    clear_inputs();
    check("t5_pass_cnt", 64'(pass_cnt), 64'd16);

    // Randomised traffic against the model
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      cfg_check_cyc = 1'($urandom % 2);
      cfg_stop_on_err = (seg == 3);
      for (int n = 0; n < 500; n++) begin
        clear_inputs();
        for (int i = 0; i < NL; i++) begin
          logic [1:0]    k;
          logic [TW-1:0] t;
          if ($urandom % 10 < 6) begin
            k = 2'($urandom % 4);
            t = TW'($urandom % 8);
            if (k == 2'd3) t = TW'(($urandom % 64) << 2);
            set_lane(i, k, t, {$urandom, $urandom});
          end
        end
        if ($urandom % 4 != 0) begin
          if (mq.size() != 0) begin
            int r;
            r = $urandom % 10;
            exp_from_head(r < 6 ? 0 : (r < 7 ? 1 : 2));
          end else begin
            set_exp(1, 2'($urandom % 4), TW'($urandom), {$urandom, $urandom}, CW'($urandom),
                    1'($urandom % 2));
          end
        end
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
